// File: rtl/lfsr_checker.sv
// Serial PRBS checker: self-synchronises an internal LFSR to the received stream, then counts
// bit errors against the free-running prediction and drops lock on a burst of errors.
module lfsr_checker #(
   parameter int unsigned WIDTH      = 15,
   parameter int unsigned TAP_A      = 14,
   parameter int unsigned TAP_B      = 13,
   parameter int unsigned VERIFY_LEN = 32,
   parameter int unsigned WINDOW     = 64,
   parameter int unsigned LOSS_ERRS  = 8
) (
   input  logic        ADC_CLK_10,
   input  logic        rst_n,
   input  logic        bit_in,
   input  logic        bit_valid,
   input  logic        clr_count,
   output logic        locked,
   output logic        err_pulse,
   output logic [15:0] err_count,
   output logic [1:0]  state
);

   localparam int unsigned FillW  = $clog2(WIDTH + 1);
   localparam int unsigned MatchW = $clog2(VERIFY_LEN + 1);
   localparam int unsigned WinW   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
   localparam int unsigned WerrW  = $clog2(LOSS_ERRS + 1);

   typedef enum logic [1:0] {
      StSearch = 2'd0,
      StVerify = 2'd1,
      StLocked = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   sr_q, sr_d;
   logic [FillW-1:0]   fill_q, fill_d;
   logic [MatchW-1:0]  match_q, match_d;
   logic [WinW-1:0]    win_q, win_d;
   logic [WerrW-1:0]   werr_q, werr_d;
   logic [WerrW-1:0]   werr_sum;
   logic [15:0]        err_count_q, err_count_d;
   logic               err_pulse_q, err_pulse_d;
   logic               locked_q;
   logic               predict;
   logic               mismatch;

   assign predict  = sr_q[TAP_A] ^ sr_q[TAP_B];
   assign mismatch = bit_in ^ predict;

   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      fill_d      = fill_q;
      match_d     = match_q;
      win_d       = win_q;
      werr_d      = werr_q;
      werr_sum    = werr_q;
      err_pulse_d = 1'b0;

      unique case (state_q)
         StSearch: begin
            if (bit_valid) begin
               sr_d   = {sr_q[WIDTH-2:0], bit_in};
               fill_d = fill_q + FillW'(1);
               if (fill_q == FillW'(WIDTH - 1)) begin
                  state_d = StVerify;
                  match_d = '0;
               end
            end
         end
         StVerify: begin
            // An all-zero register would predict zeros forever; never trust it.
            if (sr_q == '0) begin
               state_d = StSearch;
               fill_d  = '0;
            end else if (bit_valid) begin
               if (mismatch) begin
                  state_d = StSearch;
                  fill_d  = '0;
               end else begin
                  sr_d    = {sr_q[WIDTH-2:0], bit_in};
                  match_d = match_q + MatchW'(1);
                  if (match_q == MatchW'(VERIFY_LEN - 1)) begin
                     state_d = StLocked;
                     win_d   = '0;
                     werr_d  = '0;
                  end
               end
            end
         end
         StLocked: begin
            if (sr_q == '0) begin
               state_d = StSearch;
               fill_d  = '0;
            end else if (bit_valid) begin
               // Free-run on the prediction so a line error cannot corrupt the generator.
               sr_d        = {sr_q[WIDTH-2:0], predict};
               err_pulse_d = mismatch;
               werr_sum    = werr_q + WerrW'(mismatch);
               if (werr_sum == WerrW'(LOSS_ERRS)) begin
                  state_d = StSearch;
                  fill_d  = '0;
               end else if (win_q == WinW'(WINDOW - 1)) begin
                  win_d  = '0;
                  werr_d = '0;
               end else begin
                  win_d  = win_q + WinW'(1);
                  werr_d = werr_sum;
               end
            end
         end
         default: begin
            state_d = StSearch;
            fill_d  = '0;
         end
      endcase
   end

   always_comb begin
      err_count_d = err_count_q;
      if (clr_count) begin
         err_count_d = '0;
      end else if (err_pulse_d && (err_count_q != 16'hFFFF)) begin
         err_count_d = err_count_q + 16'd1;
      end
   end

   always_ff @(posedge ADC_CLK_10 or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StSearch;
         sr_q        <= '0;
         fill_q      <= '0;
         match_q     <= '0;
         win_q       <= '0;
         werr_q      <= '0;
         err_count_q <= '0;
         err_pulse_q <= 1'b0;
         locked_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         fill_q      <= fill_d;
         match_q     <= match_d;
         win_q       <= win_d;
         werr_q      <= werr_d;
         err_count_q <= err_count_d;
         err_pulse_q <= err_pulse_d;
         locked_q    <= (state_d == StLocked);
      end
   end

   assign locked    = locked_q;
   assign err_pulse = err_pulse_q;
   assign err_count = err_count_q;
   assign state     = state_q;

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: PRBS-15 stream with injected errors, checked against a queue-based
// model of the received bit history.
module tb_lfsr_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        bit_in;
   logic        bit_valid;
   logic        clr_count;
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_count;
   logic [1:0]  state;

   lfsr_checker dut (
      .ADC_CLK_10 (clk),
      .rst_n      (rst_n),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .clr_count  (clr_count),
      .locked     (locked),
      .err_pulse  (err_pulse),
      .err_count  (err_count),
      .state      (state)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;
   int npulse  = 0;

   // Reference model: hist holds the last 15 accepted bits, hist[0] being the oldest.
   int m_mode, m_fill, m_match, m_win, m_werr, m_err;
   bit m_pulse;
   bit m_hist[$];

   logic [14:0] g_sr = 15'h0001;

   task automatic gen(output bit nb);
      nb   = g_sr[14] ^ g_sr[13];
      g_sr = {g_sr[13:0], nb};
   endtask

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      m_mode = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0; m_err = 0; m_pulse = 0;
      m_hist.delete();
      for (int i = 0; i < 15; i++) m_hist.push_back(1'b0);
   endtask

   task automatic accept(bit b);
      m_hist.push_back(b);
      void'(m_hist.pop_front());
   endtask

   task automatic model_update(bit b, bit v, bit c);
      bit p = m_hist[0] ^ m_hist[1];
      int ones = 0;
      foreach (m_hist[i]) ones += int'(m_hist[i]);
      m_pulse = 1'b0;
      if (m_mode != 0 && ones == 0) begin
         m_mode = 0; m_fill = 0;
      end else if (v) begin
         case (m_mode)
            0: begin
               accept(b);
               m_fill++;
               if (m_fill == 15) begin m_mode = 1; m_match = 0; end
            end
            1: begin
               if (b != p) begin
                  m_mode = 0; m_fill = 0;
               end else begin
                  accept(b);
                  m_match++;
                  if (m_match == 32) begin m_mode = 2; m_win = 0; m_werr = 0; end
               end
            end
            default: begin
               accept(p);
               m_pulse = (b != p);
               if (m_pulse) m_werr++;
               if (m_werr == 8) begin
                  m_mode = 0; m_fill = 0;
               end else begin
                  m_win++;
                  if (m_win == 64) begin m_win = 0; m_werr = 0; end
               end
            end
         endcase
      end
      if (c) m_err = 0;
      else if (m_pulse && m_err < 65535) m_err++;
   endtask

   task automatic check_outputs(string tag);
      check({tag, ".state"}, 32'(state), 32'(m_mode));
      check({tag, ".locked"}, 32'(locked), 32'(m_mode == 2));
      check({tag, ".err_pulse"}, 32'(err_pulse), 32'(m_pulse));
      check({tag, ".err_count"}, 32'(err_count), 32'(m_err));
   endtask

   task automatic step(bit b, bit v, bit c, string tag);
      bit_in = b; bit_valid = v; clr_count = c;
      @(posedge clk);
      model_update(b, v, c);
      @(negedge clk);
      if (err_pulse === 1'b1) npulse++;
      check_outputs(tag);
   endtask

   // Clean stream; lock_at = valid-bit index at which locked was first seen (-1 if never).
   task automatic run_clean(int n, bit rnd_valid, bit stop_on_lock, output int lock_at);
      int vc = 0;
      bit b, v;
      lock_at = -1;
      for (int i = 0; i < n; i++) begin
         v = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
         if (v) gen(b);
         else b = 1'($urandom);
         step(b, v, 1'b0, "clean");
         if (v) vc++;
         if (locked === 1'b1 && lock_at < 0) begin
            lock_at = vc;
            if (stop_on_lock) break;
         end
      end
   endtask

   task automatic pulse_reset(string tag);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int  lock_at;
      bit  b;
      bit  saw_verify, saw_locked;

      rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; clr_count = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs("reset");
      rst_n = 1'b1;

      // Clean acquisition and long error-free run.
      run_clean(10000, 1'b0, 1'b0, lock_at);
      check("lock_point", 32'(lock_at), 32'd47);
      check("clean_err_count", 32'(err_count), 32'd0);

      // Single inverted bit.
      npulse = 0;
      gen(b);
      step(~b, 1'b1, 1'b0, "single_err");
      check("single_pulse_now", 32'(err_pulse), 32'd1);
      run_clean(100, 1'b0, 1'b0, lock_at);
      check("single_pulse_total", 32'(npulse), 32'd1);
      check("single_count", 32'(err_count), 32'd1);
      check("single_locked", 32'(locked), 32'd1);

      // Reset while locked, then reacquire with 50% random valid.
      pulse_reset("midreset");
      check("midreset_locked", 32'(locked), 32'd0);
      check("midreset_count", 32'(err_count), 32'd0);
      run_clean(400, 1'b1, 1'b1, lock_at);
      check("rnd_valid_lock_point", 32'(lock_at), 32'd47);

      // Eight errors early in a fresh window force loss of lock.
      for (int k = 0; k < 15; k++) begin
         gen(b);
         step((k % 2 == 0) ? ~b : b, 1'b1, 1'b0, "burst");
      end
      check("burst_state", 32'(state), 32'd0);
      check("burst_count", 32'(err_count), 32'd8);
      run_clean(46, 1'b0, 1'b0, lock_at);
      check("relock_not_early", 32'(locked), 32'd0);
      run_clean(1, 1'b0, 1'b0, lock_at);
      check("relock_47", 32'(locked), 32'd1);
      check("relock_count", 32'(err_count), 32'd8);

      // Saturation and clear priority.
      force dut.err_count_q = 16'hFFFE;
      #1 release dut.err_count_q;
      m_err = 16'hFFFE;
      check("sat_preload", 32'(err_count), 32'hFFFE);
      for (int k = 0; k < 3; k++) begin
         gen(b);
         step(~b, 1'b1, 1'b0, "sat");
      end
      check("sat_hold", 32'(err_count), 32'hFFFF);
      gen(b);
      step(~b, 1'b1, 1'b1, "clr_vs_err");
      check("clr_priority", 32'(err_count), 32'd0);
      check("clr_pulse", 32'(err_pulse), 32'd1);

      // Idle cycles with random data change nothing.
      for (int k = 0; k < 20; k++) step(1'($urandom), 1'b0, 1'b0, "idle");
      check("idle_locked", 32'(locked), 32'd1);

      // Constant-zero input never locks.
      pulse_reset("zero_reset");
      saw_verify = 1'b0; saw_locked = 1'b0;
      for (int k = 0; k < 300; k++) begin
         step(1'b0, 1'b1, 1'b0, "zero");
         if (state == 2'd1) saw_verify = 1'b1;
         if (locked !== 1'b0) saw_locked = 1'b1;
      end
      check("zero_saw_verify", 32'(saw_verify), 32'd1);
      check("zero_never_locked", 32'(saw_locked), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
